// File: rtl/board_rx_assembler_if.sv
// rtl/board_rx_assembler_if.sv - UART byte stream in, committed board frame out
interface board_rx_assembler_if;
    logic [7:0]             byte_in;
    logic                   byte_valid;
    logic [8:0][8:0][1:0]   board_out;
    logic                   rx_ready;
    logic                   frame_done;
    logic                   frame_err;
    logic [1:0]             err_code;

    modport master (
        output byte_in, byte_valid,
        input  board_out, rx_ready, frame_done, frame_err, err_code
    );

    modport slave (
        input  byte_in, byte_valid,
        output board_out, rx_ready, frame_done, frame_err, err_code
    );
endinterface

// File: rtl/board_rx_assembler.sv
// rtl/board_rx_assembler.sv - assembles and checks 9x9 Go board frames from a UART byte stream
module board_rx_assembler #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk_in,
    input  logic                   reset,
    board_rx_assembler_if.slave    rx
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_CSUM = 2'd2;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [4:0]             idx_q, idx_d;
    logic [7:0]             xor_q, xor_d;
    logic                   cerr_q, cerr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [161:0]           shadow_q, shadow_d;
    logic [8:0][8:0][1:0]   board_q, board_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;
    logic [1:0]             code_q, code_d;

    logic [7:0] b;
    logic       last_byte;
    logic       byte_bad;
    logic       tmo_fire;

    assign b         = rx.byte_in;
    assign last_byte = (idx_q == 5'd20);
    // D20 holds only cell 80; its upper six bits act as mandatory zero padding
    assign byte_bad  = last_byte ? ((b[7:2] != 6'd0) | (&b[1:0]))
                                 : ((&b[1:0]) | (&b[3:2]) | (&b[5:4]) | (&b[7:6]));
    assign tmo_fire  = (TIMEOUT_CYCLES != 0) && (state_q != S_IDLE) && (cnt_q == TMAX);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        cerr_d   = cerr_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        board_d  = board_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        ferr_d   = 1'b0;
        code_d   = code_q;
        if (tmo_fire) begin
            // the timeout has priority over a byte landing on the same cycle
            state_d = S_IDLE;
            cnt_d   = '0;
            ferr_d  = 1'b1;
            code_d  = 2'b11;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx.byte_valid && b == SYNC_BYTE) begin
                        state_d = S_DATA;
                        idx_d   = 5'd0;
                        xor_d   = 8'd0;
                        cerr_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    if (rx.byte_valid) begin
                        if (last_byte) begin
                            shadow_d[161:160] = b[1:0];
                            state_d = S_CSUM;
                        end else begin
                            shadow_d[int'(idx_q)*8 +: 8] = b;
                        end
                        xor_d  = xor_q ^ b;
                        cerr_d = cerr_q | byte_bad;
                        idx_d  = idx_q + 5'd1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_CSUM: begin
                    if (rx.byte_valid) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        if (cerr_q) begin
                            ferr_d = 1'b1;
                            code_d = 2'b10;
                        end else if (xor_q != b) begin
                            ferr_d = 1'b1;
                            code_d = 2'b01;
                        end else begin
                            board_d = shadow_q;
                            done_d  = 1'b1;
                            ready_d = 1'b1;
                            code_d  = 2'b00;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 5'd0;
            xor_q    <= 8'd0;
            cerr_q   <= 1'b0;
            cnt_q    <= '0;
            shadow_q <= '0;
            board_q  <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            cerr_q   <= cerr_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            board_q  <= board_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
            code_q   <= code_d;
        end
    end

    assign rx.board_out  = board_q;
    assign rx.rx_ready   = ready_q;
    assign rx.frame_done = done_q;
    assign rx.frame_err  = ferr_q;
    assign rx.err_code   = code_q;
endmodule

// File: tb/tb_board_rx_assembler.sv
// tb/tb_board_rx_assembler.sv - scoreboard bench for board_rx_assembler
module tb_board_rx_assembler;
    typedef logic [7:0] frame_t [21];
    typedef logic [8:0][8:0][1:0] board_t;
    typedef struct {
        logic       is_err;
        logic [1:0] code;
        board_t     board;
        logic       ready;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t expq[$];
    board_t cur_board = '0;
    logic   cur_ready = 1'b0;

    board_rx_assembler_if bif ();

    board_rx_assembler #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)) dut (
        .clk_in (clk),
        .reset  (reset),
        .rx     (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic board_t decode(input frame_t d);
        board_t r;
        r = '0;
        for (int n = 0; n < 81; n++) begin
            logic [7:0] byt;
            byt = d[n / 4];
            r[n / 9][n % 9] = byt[2 * (n % 4) +: 2];
        end
        return r;
    endfunction

    function automatic logic [7:0] csum(input frame_t d);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 21; i++) x = x ^ d[i];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] v);
        bif.byte_in    = v;
        bif.byte_valid = 1'b1;
        @(posedge clk);
        #1;
        bif.byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input frame_t d, input logic [7:0] c,
                              input logic is_err, input logic [1:0] code);
        exp_t e;
        if (!is_err) begin
            cur_board = decode(d);
            cur_ready = 1'b1;
        end
        e.is_err = is_err;
        e.code   = code;
        e.board  = cur_board;
        e.ready  = cur_ready;
        expq.push_back(e);
        send_byte(8'hA5);
        for (int i = 0; i < 21; i++) send_byte(d[i]);
        send_byte(c);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (expq.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected events still pending", name, expq.size());
            expq.delete();
        end
    endtask

    // Monitor: every frame_done/frame_err pulse consumes one expectation
    always @(negedge clk) begin
        if (!reset && (bif.frame_done || bif.frame_err)) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: done=%b err=%b code=%b",
                         bif.frame_done, bif.frame_err, bif.err_code);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("evt_done", 162'(bif.frame_done), 162'(!e.is_err));
                chk("evt_err", 162'(bif.frame_err), 162'(e.is_err));
                chk("evt_code", 162'(bif.err_code), 162'(e.code));
                chk("evt_board", bif.board_out, e.board);
                chk("evt_ready", 162'(bif.rx_ready), 162'(e.ready));
            end
        end
    end

    frame_t f1, f5, f20, g2, g3, part;

    initial begin
        bif.byte_in    = 8'h00;
        bif.byte_valid = 1'b0;
        f1 = '{default: 8'h00};
        f1[0] = 8'h01; f1[20] = 8'h02;
        f5 = f1;  f5[5] = 8'h03;
        f20 = f1; f20[20] = 8'h06;
        for (int i = 0; i < 21; i++) g2[i] = (i % 3 == 0) ? 8'h19 : (i % 3 == 1) ? 8'h86 : 8'hA5;
        g2[20] = 8'h01;
        for (int i = 0; i < 21; i++) g3[i] = (i % 2 == 0) ? 8'h24 : 8'h52;
        g3[20] = 8'h02;
        for (int i = 0; i < 21; i++) part[i] = 8'h55;

        idle(3);
        reset = 1'b0;
        idle(100);
        chk("rst_board", bif.board_out, '0);
        chk("rst_ready", 162'(bif.rx_ready), 162'(0));
        chk("rst_done", 162'(bif.frame_done), 162'(0));
        chk("rst_err", 162'(bif.frame_err), 162'(0));
        chk("rst_code", 162'(bif.err_code), 162'(0));

        send_frame(f1, 8'h03, 1'b0, 2'b00);
        wait_drain("good_f1", 10);
        chk("f1_cell00", 162'(bif.board_out[0][0]), 162'(2'b01));
        chk("f1_cell88", 162'(bif.board_out[8][8]), 162'(2'b10));
        chk("f1_ready", 162'(bif.rx_ready), 162'(1));
        chk("f1_done_1cyc", 162'(bif.frame_done), 162'(0));

        send_frame(f1, 8'h07, 1'b1, 2'b01);
        send_frame(f5, 8'h00, 1'b1, 2'b10);
        send_frame(f20, 8'h07, 1'b1, 2'b10);
        wait_drain("err_frames", 10);
        chk("err_code_hold", 162'(bif.err_code), 162'(2'b10));

        begin
            exp_t e;
            e.is_err = 1'b1; e.code = 2'b11; e.board = cur_board; e.ready = cur_ready;
            expq.push_back(e);
            send_byte(8'hA5);
            for (int i = 0; i < 10; i++) send_byte(8'h11);
            wait_drain("timeout", 60);
        end
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        send_frame(g2, csum(g2), 1'b0, 2'b00);
        wait_drain("after_timeout", 10);

        send_byte(8'hA5);
        for (int i = 0; i < 13; i++) send_byte(part[i]);
        reset = 1'b1;
        bif.byte_in = 8'h55; bif.byte_valid = 1'b1;
        idle(1);
        reset = 1'b0;
        bif.byte_valid = 1'b0;
        cur_board = '0;
        cur_ready = 1'b0;
        chk("midrst_board", bif.board_out, '0);
        chk("midrst_ready", 162'(bif.rx_ready), 162'(0));
        chk("midrst_code", 162'(bif.err_code), 162'(0));
        send_frame(g3, csum(g3), 1'b0, 2'b00);
        wait_drain("fresh_frame", 10);

        send_frame(g2, csum(g2), 1'b0, 2'b00);
        send_frame(f1, 8'h03, 1'b0, 2'b00);
        wait_drain("back_to_back", 10);
        chk("final_board", bif.board_out, decode(f1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/board_rx_assembler.md
Name: board_rx_assembler

Overview:
- Sits directly upstream of the game FSM.
- Consumes the byte stream from the UART receiver and assembles a complete 9x9 Go board frame.
- Checks every frame and presents it atomically on board_out, with rx_ready as the level qualifier the FSM uses to select the received board.
- A partial or corrupt frame never reaches board_out.

Parameters:
- SYNC_BYTE, 8'hA5, frame header byte.
- TIMEOUT_CYCLES, 1_000_000, maximum clk_in cycles between accepted bytes inside a frame. 0 disables the timeout.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- byte_in  input  8  received byte from UART.
- byte_valid  input  1  one-cycle strobe; byte_in is valid when high.
- board_out  output  [1:0] [8:0][8:0]  committed board, same encoding as the FSM's board_in: 00 empty, 01 black, 10 white.
- rx_ready  output  1  high once at least one good frame has been committed.
- frame_done  output  1  one-cycle pulse on each commit.
- frame_err  output  1  one-cycle pulse on each frame abort.
- err_code  output  2  last error: 00 none, 01 checksum, 10 illegal cell/pad, 11 timeout.

Behaviour:
- Frame format: SYNC_BYTE, then 21 data bytes D0..D20, then 1 checksum byte C.
- Cell n = row*9+col maps to board_out[row][col]. Cell n is stored in byte D(n/4) at bits [2*(n%4)+1 : 2*(n%4)].
- D20 carries only cell 80 in bits [1:0]. Bits [7:2] of D20 must be 0.
- C must equal the XOR of D0..D20.
- States: IDLE, DATA, CSUM.
  - IDLE: byte_valid with byte_in==SYNC_BYTE -> DATA, byte index=0, running XOR=0, cell_err=0. Any other byte is ignored silently with no error.
  - DATA: each valid byte is written into the shadow board, XORed into the running XOR, and the index is incremented.
    - Any 2'b11 cell, or nonzero D20[7:2], sets cell_err.
    - After D20 is accepted -> CSUM.
    - SYNC_BYTE inside data is treated as ordinary data; there is no resync.
  - CSUM: on a valid byte -> IDLE, with one of three outcomes:
    - cell_err set: frame_err=1, err_code=10.
    - Otherwise, running XOR != byte: frame_err=1, err_code=01.
    - Otherwise: the shadow board is copied to board_out, frame_done=1, rx_ready=1, err_code=00.
- Latency: board_out, frame_done and rx_ready update on the clock edge that samples C, so they are visible the cycle after C is presented.
- board_out changes only on commit, and all 81 cells change on the same edge.
- rx_ready is sticky: it stays 1 through later errors and clears only on reset.
- Timeout: a counter runs in DATA and CSUM and clears on every accepted byte. When it reaches TIMEOUT_CYCLES with no byte -> IDLE, frame_err=1, err_code=11. It does not run in IDLE.
- A byte arriving on the same cycle the timeout fires is dropped, and the timeout wins.
- err_code holds its value until the next frame_done or frame_err.
- Shadow-board contents of an aborted frame are discarded and never visible.
- Reset (any state, including mid-frame) sets:
  - state=IDLE;
  - board_out all 2'b00, with the shadow board cleared to match;
  - rx_ready=0, frame_done=0, frame_err=0, err_code=00;
  - counters 0.
- byte_valid is ignored during the reset cycle.

Test Plan:
- Reset then idle 100 cycles -> board_out all 00, rx_ready=0, frame_done=0, frame_err=0, err_code=00.
- Good frame: A5, D0=01, D1..D19=00, D20=02, C=03 -> the cycle after C, board_out[0][0]=01, board_out[8][8]=10, all other cells 00, frame_done pulses for 1 cycle, rx_ready=1.
- Same frame with C=07 -> frame_err pulse, err_code=01, board_out unchanged, rx_ready unchanged.
- D5=03 (cell 20 = 2'b11), correct XOR -> err_code=10. Separately, D20=06 with correct XOR -> err_code=10. Board unchanged in both cases.
- With TIMEOUT_CYCLES=50, send A5 and 10 data bytes, then stall 50 cycles -> frame_err, err_code=11, state IDLE. Then 3 garbage bytes 00/FF/12 followed by a complete good frame -> the good frame commits normally.
- Assert reset after D12 of a frame, then send a fresh good frame -> only the fresh frame commits. Then two good frames back to back with zero idle cycles between them -> two frame_done pulses, and board_out equals the second frame.
